// File: rtl/fetch_unit.sv
// Fetch stage: PC, instruction register and return-address stack for call/ret.
// Optional FETCH_ERR_EN implements sticky overflow/underflow error flags.
module fetch_unit #(
    parameter int AW     = 10,
    parameter int IW     = 16,
    parameter int SDEPTH = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          stall,
    input  logic          jump,
    input  logic          call,
    input  logic          ret,
    input  logic [AW-1:0] jaddr,
    output logic [AW-1:0] Address,
    input  logic [IW-1:0] Data,
    output logic [IW-1:0] instr,
    output logic          instr_valid,
    output logic [AW-1:0] instr_pc,
    output logic          stk_full,
    output logic          stk_empty,
    output logic          err_ovf,
    output logic          err_unf
);

    localparam int SPW = $clog2(SDEPTH) + 1;

    logic [AW-1:0]  pc;
    logic [AW-1:0]  pc_next;
    logic [SPW-1:0] sp;
    logic [SPW-2:0] push_idx;
    logic [SPW-2:0] top_idx;
    logic [AW-1:0]  ret_addr;
    logic [AW-1:0]  stack [SDEPTH];

    logic ret_ok;
    logic call_ok;
    logic jump_ok;
    logic redirect;

    assign Address   = pc;
    assign stk_full  = (sp == SPW'(SDEPTH));
    assign stk_empty = (sp == '0);
    assign push_idx  = sp[SPW-2:0];
    assign top_idx   = push_idx - 1'b1;
    assign ret_addr  = instr_pc + 1'b1;

    // Controls belong to the word in instr, so a bubble cannot redirect.
    assign ret_ok   = instr_valid && ret;
    assign call_ok  = instr_valid && call && !ret;
    assign jump_ok  = instr_valid && jump && !ret && !call;
    assign redirect = ret_ok || call_ok || jump_ok;

    always_comb begin
        pc_next = pc + 1'b1;
        if (ret_ok) begin
            pc_next = stk_empty ? '0 : stack[top_idx];
        end else if (call_ok || jump_ok) begin
            pc_next = jaddr;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc          <= '0;
            instr       <= '0;
            instr_valid <= 1'b0;
            instr_pc    <= '0;
            sp          <= '0;
        end else if (!stall) begin
            instr       <= Data;
            instr_pc    <= pc;
            instr_valid <= !redirect;
            pc          <= pc_next;
            if (call_ok && !stk_full) begin
                sp <= sp + 1'b1;
            end else if (ret_ok && !stk_empty) begin
                sp <= sp - 1'b1;
            end
        end
    end

    // Stack storage needs no reset; sp alone defines which entries are live.
    always_ff @(posedge clk) begin
        if (!reset && !stall && call_ok && !stk_full) begin
            stack[push_idx] <= ret_addr;
        end
    end

`ifdef FETCH_ERR_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_ovf <= 1'b0;
            err_unf <= 1'b0;
        end else if (!stall) begin
            if (call_ok && stk_full) begin
                err_ovf <= 1'b1;
            end
            if (ret_ok && stk_empty) begin
                err_unf <= 1'b1;
            end
        end
    end
`else
    assign err_ovf = 1'b0;
    assign err_unf = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus random controls against a queue-based model.
module tb_fetch_unit;

    localparam int AW     = 10;
    localparam int IW     = 16;
    localparam int SDEPTH = 8;
`ifdef FETCH_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          stall;
    logic          jump;
    logic          call;
    logic          ret;
    logic [AW-1:0] jaddr;
    logic [AW-1:0] Address;
    logic [IW-1:0] Data;
    logic [IW-1:0] instr;
    logic          instr_valid;
    logic [AW-1:0] instr_pc;
    logic          stk_full;
    logic          stk_empty;
    logic          err_ovf;
    logic          err_unf;

    logic [IW-1:0] mem [1024];
    assign Data = mem[Address];

    int vectors = 0;
    int miscompares = 0;

    // Reference model state
    int m_pc;
    int m_instr;
    bit m_valid;
    int m_ipc;
    int m_stk[$];
    bit m_ovf;
    bit m_unf;

    fetch_unit #(.AW(AW), .IW(IW), .SDEPTH(SDEPTH)) dut (
        .clk(clk), .reset(reset), .stall(stall), .jump(jump), .call(call), .ret(ret),
        .jaddr(jaddr), .Address(Address), .Data(Data), .instr(instr),
        .instr_valid(instr_valid), .instr_pc(instr_pc), .stk_full(stk_full),
        .stk_empty(stk_empty), .err_ovf(err_ovf), .err_unf(err_unf)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_pc = 0; m_instr = 0; m_valid = 0; m_ipc = 0;
        m_stk.delete();
        m_ovf = 0; m_unf = 0;
    endtask

    task automatic step(input bit s, input bit j, input bit c, input bit r, input int ja);
        int nx;
        bit red;
        stall = s; jump = j; call = c; ret = r; jaddr = AW'(ja);
        if (!s) begin
            nx  = (m_pc + 1) % 1024;
            red = 0;
            if (m_valid && r) begin
                red = 1;
                if (m_stk.size() == 0) begin
                    nx = 0; m_unf = ERR_EN;
                end else begin
                    nx = m_stk.pop_back();
                end
            end else if (m_valid && c) begin
                red = 1;
                if (m_stk.size() == SDEPTH) m_ovf = ERR_EN;
                else m_stk.push_back((m_ipc + 1) % 1024);
                nx = ja;
            end else if (m_valid && j) begin
                red = 1;
                nx = ja;
            end
            m_instr = int'(mem[m_pc]);
            m_ipc   = m_pc;
            m_valid = !red;
            m_pc    = nx;
        end
        @(posedge clk);
        #1;
        stall = 0; jump = 0; call = 0; ret = 0;
    endtask

    task automatic test_reset();
        reset = 1; stall = 0; jump = 0; call = 0; ret = 0; jaddr = '0;
        model_reset();
        #2;
        vectors++;
        if ({Address, instr, instr_valid, instr_pc} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs got A=%h I=%h V=%b P=%h exp all zero", Address, instr, instr_valid, instr_pc);
        end
        vectors++;
        if ({stk_full, stk_empty, err_ovf, err_unf} !== 4'b0100) begin
            miscompares++;
            $display("FAIL reset_flags got %b exp 0100", {stk_full, stk_empty, err_ovf, err_unf});
        end
        #1 reset = 0;
        vectors++;
        if (instr_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL pre_edge_valid got %b exp 0", instr_valid);
        end
    endtask

    task automatic test_sequential();
        for (int n = 0; n < 4; n++) begin
            step(0, 0, 0, 0, 0);
            vectors++;
            if (instr !== IW'(16'h1000 + n) || instr_pc !== AW'(n) || instr_valid !== 1'b1) begin
                miscompares++;
                $display("FAIL seq_%0d got I=%h P=%h V=%b exp I=%h P=%h V=1", n, instr, instr_pc, instr_valid, 16'h1000 + n, n);
            end
        end
    endtask

    task automatic test_jump();
        while (m_ipc != 5) step(0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 'h3F0);
        vectors++;
        if (instr_valid !== 1'b0 || instr_pc !== AW'(6)) begin
            miscompares++;
            $display("FAIL jump_bubble got V=%b P=%h exp V=0 P=006", instr_valid, instr_pc);
        end
        step(0, 0, 0, 0, 0);
        vectors++;
        if (instr_valid !== 1'b1 || instr_pc !== AW'('h3F0) || instr !== mem['h3F0]) begin
            miscompares++;
            $display("FAIL jump_target got V=%b P=%h I=%h exp V=1 P=3f0 I=%h", instr_valid, instr_pc, instr, mem['h3F0]);
        end
    endtask

    task automatic test_call_ret();
        step(0, 1, 0, 0, 7);
        step(0, 0, 0, 0, 0);
        step(0, 0, 1, 0, 'h100);
        vectors++;
        if (instr_valid !== 1'b0 || stk_empty !== 1'b0) begin
            miscompares++;
            $display("FAIL call_bubble got V=%b E=%b exp V=0 E=0", instr_valid, stk_empty);
        end
        for (int k = 0; k < 3; k++) step(0, 0, 0, 0, 0);
        vectors++;
        if (instr_pc !== AW'('h102) || instr_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL call_body got P=%h V=%b exp P=102 V=1", instr_pc, instr_valid);
        end
        step(0, 0, 0, 1, 0);
        vectors++;
        if (instr_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL ret_bubble got V=%b exp 0", instr_valid);
        end
        step(0, 0, 0, 0, 0);
        vectors++;
        if (instr_pc !== AW'(8) || instr_valid !== 1'b1 || stk_empty !== 1'b1 || instr !== IW'(16'h1008)) begin
            miscompares++;
            $display("FAIL ret_target got P=%h V=%b E=%b I=%h exp P=008 V=1 E=1 I=1008", instr_pc, instr_valid, stk_empty, instr);
        end
    endtask

    task automatic test_wrap();
        step(0, 1, 0, 0, 1022);
        for (int k = 0; k < 4; k++) begin
            step(0, 0, 0, 0, 0);
            vectors++;
            if (instr_pc !== AW'((1022 + k) % 1024) || instr_valid !== 1'b1) begin
                miscompares++;
                $display("FAIL wrap_%0d got P=%h V=%b exp P=%h V=1", k, instr_pc, instr_valid, (1022 + k) % 1024);
            end
        end
    endtask

    task automatic test_overflow();
        for (int i = 0; i <= SDEPTH; i++) begin
            step(0, 0, 1, 0, 'h200 + i * 4);
            step(0, 0, 0, 0, 0);
            if (i == SDEPTH - 1) begin
                vectors++;
                if (stk_full !== 1'b1 || err_ovf !== 1'b0) begin
                    miscompares++;
                    $display("FAIL full_at_depth got F=%b O=%b exp F=1 O=0", stk_full, err_ovf);
                end
            end
        end
        vectors++;
        if (stk_full !== 1'b1 || err_ovf !== ERR_EN || instr_pc !== AW'('h200 + SDEPTH * 4)) begin
            miscompares++;
            $display("FAIL overflow got F=%b O=%b P=%h exp F=1 O=%b P=%h", stk_full, err_ovf, instr_pc, ERR_EN, 'h200 + SDEPTH * 4);
        end
        for (int i = 0; i < SDEPTH; i++) begin
            step(0, 0, 0, 1, 0);
            step(0, 0, 0, 0, 0);
            vectors++;
            if (instr_pc !== AW'(m_ipc) || instr_valid !== 1'b1) begin
                miscompares++;
                $display("FAIL unwind_%0d got P=%h V=%b exp P=%h V=1", i, instr_pc, instr_valid, m_ipc);
            end
        end
        vectors++;
        if (stk_empty !== 1'b1 || err_unf !== 1'b0) begin
            miscompares++;
            $display("FAIL unwound got E=%b U=%b exp E=1 U=0", stk_empty, err_unf);
        end
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0);
        vectors++;
        if (instr_pc !== '0 || instr_valid !== 1'b1 || err_unf !== ERR_EN || stk_empty !== 1'b1) begin
            miscompares++;
            $display("FAIL underflow got P=%h V=%b U=%b E=%b exp P=000 V=1 U=%b E=1", instr_pc, instr_valid, err_unf, stk_empty, ERR_EN);
        end
    endtask

    task automatic test_random();
        for (int cyc = 0; cyc < 400; cyc++) begin
            step($urandom_range(0, 7) == 0, $urandom_range(0, 9) == 0, $urandom_range(0, 7) == 0,
                 $urandom_range(0, 7) == 0, int'($urandom_range(0, 1023)));
            vectors++;
            if (Address !== AW'(m_pc)) begin
                miscompares++;
                $display("FAIL rnd_addr cyc %0d got %h exp %h", cyc, Address, m_pc);
            end
            vectors++;
            if (instr !== IW'(m_instr) || instr_pc !== AW'(m_ipc) || instr_valid !== m_valid) begin
                miscompares++;
                $display("FAIL rnd_ir cyc %0d got I=%h P=%h V=%b exp I=%h P=%h V=%b", cyc, instr, instr_pc, instr_valid, m_instr, m_ipc, m_valid);
            end
            vectors++;
            if (stk_full !== (m_stk.size() == SDEPTH) || stk_empty !== (m_stk.size() == 0)) begin
                miscompares++;
                $display("FAIL rnd_flags cyc %0d got F=%b E=%b exp depth %0d", cyc, stk_full, stk_empty, m_stk.size());
            end
            vectors++;
            if (err_ovf !== m_ovf || err_unf !== m_unf) begin
                miscompares++;
                $display("FAIL rnd_err cyc %0d got O=%b U=%b exp O=%b U=%b", cyc, err_ovf, err_unf, m_ovf, m_unf);
            end
        end
    endtask

    task automatic test_stall_reset();
        logic [AW-1:0] hold_a;
        logic [IW-1:0] hold_i;
        logic [AW-1:0] hold_p;
        step(0, 0, 0, 0, 0);
        hold_a = Address; hold_i = instr; hold_p = instr_pc;
        for (int k = 0; k < 3; k++) begin
            step(1, 1, 0, 0, 'h055);
            vectors++;
            if (Address !== hold_a || instr !== hold_i || instr_pc !== hold_p || Address !== AW'(m_pc)) begin
                miscompares++;
                $display("FAIL stall_hold_%0d got A=%h I=%h P=%h exp A=%h I=%h P=%h", k, Address, instr, instr_pc, hold_a, hold_i, hold_p);
            end
        end
        stall = 1; jump = 1; jaddr = 'h055;
        #2 reset = 1;
        #1;
        vectors++;
        if ({Address, instr, instr_valid, instr_pc, err_ovf, err_unf} !== '0 || stk_empty !== 1'b1) begin
            miscompares++;
            $display("FAIL async_reset got A=%h I=%h V=%b P=%h O=%b U=%b E=%b exp zeros E=1", Address, instr, instr_valid, instr_pc, err_ovf, err_unf, stk_empty);
        end
        stall = 0; jump = 0;
        model_reset();
        @(posedge clk);
        #1 reset = 0;
        step(0, 0, 0, 0, 0);
        vectors++;
        if (instr !== IW'(16'h1000) || instr_pc !== '0 || instr_valid !== 1'b1 || Address !== AW'(1)) begin
            miscompares++;
            $display("FAIL post_reset got I=%h P=%h V=%b A=%h exp I=1000 P=000 V=1 A=001", instr, instr_pc, instr_valid, Address);
        end
    endtask

    initial begin
        for (int n = 0; n < 1024; n++) mem[n] = IW'(16'h1000 + n);
        test_reset();
        test_sequential();
        test_jump();
        test_call_ret();
        test_wrap();
        test_overflow();
        test_random();
        test_stall_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
